// File: rtl/lag_pkg.sv
// Shared types and constants for the lag measurement block.
package lag_pkg;

    localparam int BIN_WIDTH = 17;
    localparam int BCD_WIDTH = 20;

    localparam logic [BCD_WIDTH-1:0] BCD_HIDE = 20'h99999;

    localparam int CUR_LSB = 0;
    localparam int MIN_LSB = BCD_WIDTH;
    localparam int MAX_LSB = 2 * BCD_WIDTH;
    localparam int AVG_LSB = 3 * BCD_WIDTH;

    localparam logic [4*BCD_WIDTH-1:0] BCD_RESET = {BCD_HIDE, {BCD_WIDTH{1'b0}}, BCD_HIDE, BCD_HIDE};

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        TIMEOUT,
        UPDATE,
        CONVERT,
        DONE
    } lag_state_t;

endpackage

// File: rtl/lag_measure_bin2bcd.sv
// Sequential double-dabble converter: one bit per clock, done pulses 17 clocks after start.
module bin2bcd
    import lag_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic [BCD_WIDTH-1:0] bcd,
    output logic                 done
);

    logic [BIN_WIDTH-1:0] shift;
    logic [BCD_WIDTH-1:0] digits;
    logic [BCD_WIDTH-1:0] adjusted;
    logic [4:0]           remaining;

    always_comb begin
        adjusted = digits;
        for (int d = 0; d < BCD_WIDTH / 4; d++) begin
            if (digits[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = digits[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift     <= '0;
            digits    <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else if (start) begin
            shift     <= bin;
            digits    <= '0;
            remaining <= 5'(BIN_WIDTH);
            done      <= 1'b0;
        end else if (remaining != 5'd0) begin
            digits    <= {adjusted[BCD_WIDTH-2:0], shift[BIN_WIDTH-1]};
            shift     <= {shift[BIN_WIDTH-2:0], 1'b0};
            remaining <= remaining - 5'd1;
            done      <= (remaining == 5'd1);
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd = digits;

endmodule

// File: rtl/lag_measure.sv
// Trigger-to-sensor lag meter with cur/min/max/avg statistics published as packed BCD.
// Build option LAG_SENSOR_DEBOUNCE_EN: require DEBOUNCE_CYCLES stable clocks before accepting an edge.
//
// state   | meaning
// IDLE    | waiting for starttrigger
// MEASURE | prescaler/counter running, watching for a sensor edge
// TIMEOUT | no edge before MAX_COUNT, cur forced to MAX_COUNT
// UPDATE  | fold latched sample into cur/min/max/avg
// CONVERT | cur, min, max, avg converted to BCD into the shadow register
// DONE    | shadow copied to bcdcount, bcd_valid pulsed
module lag_measure
    import lag_pkg::*;
#(
    parameter int TICK_DIV           = 148,
    parameter int MAX_COUNT          = 99999,
    parameter int AVG_LOG2           = 4,
    parameter bit SENSOR_ACTIVE_HIGH = 1'b1,
    parameter int DEBOUNCE_CYCLES    = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   starttrigger,
    input  logic                   sensor,
    input  logic                   clear_stats,
    output logic [4*BCD_WIDTH-1:0] bcdcount,
    output logic                   bcd_valid,
    output logic                   busy
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ACC_W = BIN_WIDTH + AVG_LOG2;
    localparam logic [BIN_WIDTH-1:0] MAX_BIN  = BIN_WIDTH'(MAX_COUNT);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic                 INVERT   = !SENSOR_ACTIVE_HIGH;

    lag_state_t             state;
    logic                   sync1, sync2, prev_active, active, rise, accept;
    logic [PRE_W-1:0]       pre;
    logic [BIN_WIDTH-1:0]   count, sample;
    logic [BIN_WIDTH-1:0]   cur_bin, min_bin, max_bin, avg_bin;
    logic [BIN_WIDTH-1:0]   min_src, max_src, avg_src, operand;
    logic [ACC_W-1:0]       acc, acc_next;
    logic [AVG_LOG2-1:0]    n;
    logic [1:0]             sel, op_sel;
    logic                   conv_start, conv_done;
    logic [BCD_WIDTH-1:0]   conv_bcd;
    logic [4*BCD_WIDTH-1:0] shadow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            prev_active <= 1'b0;
        end else begin
            sync1       <= sensor;
            sync2       <= sync1;
            prev_active <= active;
        end
    end

    assign active = sync2 ^ INVERT;
    assign rise   = active & ~prev_active;

`ifdef LAG_SENSOR_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] deb_cnt;
    logic            deb_armed;

    // Only edges seen inside MEASURE arm the debounce; a drop disarms until the next edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_armed <= 1'b0;
            deb_cnt   <= '0;
        end else if (state != MEASURE) begin
            deb_armed <= 1'b0;
            deb_cnt   <= '0;
        end else if (rise) begin
            deb_armed <= 1'b1;
            deb_cnt   <= DB_W'(1);
        end else if (deb_armed && !active) begin
            deb_armed <= 1'b0;
            deb_cnt   <= '0;
        end else if (deb_armed && deb_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
            deb_cnt <= deb_cnt + DB_W'(1);
        end
    end

    assign accept = deb_armed && (deb_cnt == DB_W'(DEBOUNCE_CYCLES));
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;
    assign accept = rise;
`endif

    // A clear arriving mid-conversion must already show in the fields not yet converted.
    always_comb begin
        min_src    = clear_stats ? MAX_BIN : min_bin;
        max_src    = clear_stats ? '0      : max_bin;
        avg_src    = clear_stats ? MAX_BIN : avg_bin;
        conv_start = (state == UPDATE) || (state == TIMEOUT) ||
                     ((state == CONVERT) && conv_done && (sel != 2'd3));
        op_sel     = (state == CONVERT) ? sel + 2'd1 : 2'd0;
        operand    = '0;
        case (op_sel)
            2'd0:    operand = (state == TIMEOUT) ? MAX_BIN : sample;
            2'd1:    operand = min_src;
            2'd2:    operand = max_src;
            default: operand = avg_src;
        endcase
    end

    assign acc_next = acc + ACC_W'(sample);

    bin2bcd u_bin2bcd (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (operand),
        .bcd     (conv_bcd),
        .done    (conv_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pre       <= '0;
            count     <= '0;
            sample    <= '0;
            cur_bin   <= MAX_BIN;
            min_bin   <= MAX_BIN;
            max_bin   <= '0;
            avg_bin   <= MAX_BIN;
            acc       <= '0;
            n         <= '0;
            sel       <= '0;
            shadow    <= BCD_RESET;
            bcdcount  <= BCD_RESET;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (starttrigger) begin
                        pre   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (count == MAX_BIN) begin
                        state <= TIMEOUT;
                    end else if (accept) begin
                        sample <= count;
                        state  <= UPDATE;
                    end else if (pre == PRE_LAST) begin
                        pre   <= '0;
                        count <= count + BIN_WIDTH'(1);
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                TIMEOUT: begin
                    cur_bin <= MAX_BIN;
                    sel     <= 2'd0;
                    state   <= CONVERT;
                end
                UPDATE: begin
                    cur_bin <= sample;
                    min_bin <= (sample < min_bin) ? sample : min_bin;
                    max_bin <= (sample > max_bin) ? sample : max_bin;
                    if (n == '1) begin
                        avg_bin <= acc_next[ACC_W-1:AVG_LOG2];
                        acc     <= '0;
                        n       <= '0;
                    end else begin
                        acc <= acc_next;
                        n   <= n + AVG_LOG2'(1);
                    end
                    sel   <= 2'd0;
                    state <= CONVERT;
                end
                CONVERT: begin
                    if (conv_done) begin
                        shadow[BCD_WIDTH*sel +: BCD_WIDTH] <= conv_bcd;
                        if (sel == 2'd3) begin
                            state <= DONE;
                        end else begin
                            sel <= sel + 2'd1;
                        end
                    end
                end
                DONE: begin
                    bcdcount  <= shadow;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (clear_stats) begin
                min_bin <= MAX_BIN;
                max_bin <= '0;
                avg_bin <= MAX_BIN;
                acc     <= '0;
                n       <= '0;
            end
        end
    end

endmodule
